// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer and its tick prescaler.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEF_TICK_DIV = 50000000;
    localparam int DEF_CNT_W    = 8;

    // Prescaler counter width; never narrower than one bit.
    function automatic int presc_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 prescaler; tick is a registered flag that is high
// during the terminal cycle, so a consumer sampling it on the edge acts exactly once per period.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             PW   = presc_w(TICK_DIV);
    localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter stepped by tick_prescaler; pulses done on reaching zero.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the last loaded value at expiry.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [CNT_W-1:0] cout,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             presc_clr;
    logic             presc_term;
    logic             wrap;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [CNT_W-1:0] reload_q, reload_d;
`endif

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == ST_RUN),
        .clr   (presc_clr),
        .tick  (presc_term)
    );

    assign wrap = presc_term && (state_q == ST_RUN);

    always_comb begin
        state_d   = state_q;
        cout_d    = cout_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        presc_clr = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d  = reload_q;
`endif
        if (state_q == ST_RUN) begin
            // A tick on the pause cycle is applied before the pause takes effect.
            if (wrap) begin
                tick_d  = 1'b1;
                if (cout_q <= CNT_W'(1)) begin
                    done_d  = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (reload_q != '0) begin
                        cout_d  = reload_q;
                        state_d = pause ? ST_PAUSED : ST_RUN;
                    end else begin
                        cout_d  = '0;
                        state_d = ST_DONE;
                    end
`else
                    cout_d  = '0;
                    state_d = ST_DONE;
`endif
                end else begin
                    cout_d  = cout_q - 1'b1;
                    state_d = pause ? ST_PAUSED : ST_RUN;
                end
            end else if (pause) begin
                state_d = ST_PAUSED;
            end
        end else if (load) begin
            cout_d    = load_val;
            presc_clr = 1'b1;
            state_d   = ST_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_d  = load_val;
`endif
        end else if (start) begin
            if (state_q == ST_IDLE) begin
                if (cout_q != '0) begin
                    state_d   = ST_RUN;
                    presc_clr = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else if (state_q == ST_PAUSED) begin
                state_d = ST_RUN;
            end
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cout_q   <= '0;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign cout = cout_q;
    assign busy = busy_q;
    assign tick = tick_q;
    assign done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized bench for countdown_timer (TICK_DIV=4, CNT_W=8) with a cycle-level reference model.
module tb_countdown_timer;

    localparam int TD = 4;
    localparam int W  = 8;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         pause;
    logic [W-1:0] cout;
    logic         busy;
    logic         tick;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;
    string sect = "init";

    // Reference model: mode, remaining count, cycles spent in current tick period.
    int m_mode   = M_IDLE;
    int m_count  = 0;
    int m_phase  = 0;
    int m_reload = 0;
    int m_busy   = 0;
    int m_tick   = 0;
    int m_done   = 0;

    countdown_timer #(
        .TICK_DIV (TD),
        .CNT_W    (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .cout     (cout),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s observed=%0d expected=%0d", sect, tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit ld, input int lv, input bit st, input bit ps);
        m_tick = 0;
        m_done = 0;
        if (r) begin
            m_mode = M_IDLE; m_count = 0; m_phase = 0; m_reload = 0;
        end else if (m_mode == M_RUN) begin
            m_phase++;
            if (m_phase == TD) begin
                m_phase = 0;
                m_tick  = 1;
                if (m_count == 1) begin
                    m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (m_reload != 0) begin
                        m_count = m_reload;
                        m_mode  = ps ? M_PAUSED : M_RUN;
                    end else begin
                        m_count = 0;
                        m_mode  = M_DONE;
                    end
`else
                    m_count = 0;
                    m_mode  = M_DONE;
`endif
                end else begin
                    m_count = m_count - 1;
                    m_mode  = ps ? M_PAUSED : M_RUN;
                end
            end else if (ps) begin
                m_mode = M_PAUSED;
            end
        end else if (ld) begin
            m_count  = lv;
            m_phase  = 0;
            m_mode   = M_IDLE;
            m_reload = lv;
        end else if (st && m_mode == M_IDLE) begin
            if (m_count != 0) begin
                m_mode  = M_RUN;
                m_phase = 0;
            end else begin
                m_mode = M_DONE;
                m_done = 1;
            end
        end else if (st && m_mode == M_PAUSED) begin
            m_mode = M_RUN;
        end
        m_busy = (m_mode == M_RUN || m_mode == M_PAUSED) ? 1 : 0;
    endtask

    task automatic step(input bit r, input bit ld, input int lv, input bit st, input bit ps);
        logic [W-1:0] v;
        v        = W'(lv);
        reset    = r;
        load     = ld;
        load_val = v;
        start    = st;
        pause    = ps;
        @(posedge clk);
        model_edge(r, ld, lv, st, ps);
        #1;
        chk("cout", cout, m_count);
        chk("busy", busy, m_busy);
        chk("tick", tick, m_tick);
        chk("done", done, m_done);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0;

        sect = "reset";
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);

        sect = "count3";
        step(0, 1, 3, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int c = 1; c <= 14; c++) begin
            step(0, 0, 0, 0, 0);
            if (c == 4)  chk("c4_cout", cout, 2);
            if (c == 8)  chk("c8_cout", cout, 1);
            if (c == 12) begin
                chk("c12_cout", cout, 0);
                chk("c12_done", done, 1);
                chk("c12_busy", busy, 0);
            end
            if (c == 11) chk("c11_busy", busy, 1);
        end

        sect = "pause";
        step(0, 1, 3, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int c = 1; c <= 5; c++) step(0, 0, 0, 0, 0);
        for (int c = 6; c <= 15; c++) begin
            step(0, 0, 0, 0, 1);
            chk("frozen_cout", cout, 2);
            chk("frozen_tick", tick, 0);
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("resume1_tick", tick, 0);
        step(0, 0, 0, 0, 0);
        chk("resume2_tick", tick, 1);
        chk("resume2_cout", cout, 1);

        sect = "load_in_run";
        step(1, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int c = 1; c <= 5; c++) step(0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0);
        chk("ign_cout", cout, 2);
        chk("ign_busy", busy, 1);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("zero_done", done, 1);
        chk("zero_tick", tick, 0);
        step(0, 0, 0, 0, 0);
        chk("zero_done2", done, 0);

        sect = "mid_reset";
        step(0, 1, 3, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int c = 1; c <= 6; c++) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("mr_cout", cout, 0);
        chk("mr_busy", busy, 0);
        step(0, 0, 0, 1, 0);
        chk("mr_start_done", done, 1);
        chk("mr_start_busy", busy, 0);

        sect = "pause_term";
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int c = 1; c <= 3; c++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("pt_cout", cout, 0);
        chk("pt_tick", tick, 1);
        chk("pt_done", done, 1);
        step(0, 0, 0, 1, 0);
        chk("pt_not_paused", busy, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        sect = "auto_reload";
        step(1, 0, 0, 0, 0);
        step(0, 1, 2, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int c = 1; c <= 17; c++) begin
            step(0, 0, 0, 0, 0);
            chk("ar_busy", busy, 1);
            if (c == 4)  chk("ar_c4", cout, 1);
            if (c == 8)  begin chk("ar_c8", cout, 2);  chk("ar_d8", done, 1);  end
            if (c == 12) chk("ar_c12", cout, 1);
            if (c == 16) begin chk("ar_c16", cout, 2); chk("ar_d16", done, 1); end
        end
`endif

        sect = "random";
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit r, ld, st, ps;
            int lv;
            r  = ($urandom_range(0, 63) == 0);
            ld = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 5) == 0);
            ps = ($urandom_range(0, 11) == 0);
            lv = $urandom_range(0, 5);
            step(r, ld, lv, st, ps);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
